sklansky_sub_pipe_16: RTL and testbench



---
 rtl/sklansky_sub_pipe_16.sv | 134 +++++++++++++
 tb/tb_sklansky_sub_pipe_16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sklansky_sub_pipe_16.sv
// Two-stage pipelined 16-bit subtractor on a Sklansky prefix carry tree, valid/ready on both sides.
// Define SKLANSKY_SUB_SAT_EN to floor the difference at zero whenever a borrow occurs.
module sklansky_sub_pipe_16 #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] DIFF,
  output logic              BO
);

  localparam int LEVELS = $clog2(DATA_W);
  localparam int SPLIT  = 2;

  // PrefixBox: combine a high group (gh,ph) with the adjacent lower group (gl,pl).
  function automatic logic [1:0] prefix_box(input logic gh, input logic ph,
                                            input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

  // One Sklansky level: every bit with bit 'lvl' of its index set absorbs the
  // top bit of the preceding aligned block of width 2^lvl.
  function automatic logic [2*DATA_W-1:0] prefix_level(input logic [DATA_W-1:0] g,
                                                       input logic [DATA_W-1:0] p,
                                                       input int lvl);
    logic [DATA_W-1:0] go;
    logic [DATA_W-1:0] po;
    logic [1:0]        gp;
    int                j;
    go = g;
    po = p;
    for (int i = 0; i < DATA_W; i++) begin
      if (((i >> lvl) & 1) == 1) begin
        j     = ((i >> lvl) << lvl) - 1;
        gp    = prefix_box(g[i], p[i], g[j], p[j]);
        go[i] = gp[1];
        po[i] = gp[0];
      end
    end
    return {go, po};
  endfunction

`ifdef SKLANSKY_SUB_SAT_EN
  function automatic logic [DATA_W-1:0] sat_floor(input logic [DATA_W-1:0] d,
                                                  input logic borrow);
    return borrow ? '0 : d;
  endfunction
`endif

  logic                load_p1, load_p2, in_fire;
  logic                vld_p1, vld_p2;
  logic [DATA_W-1:0]   g_p0, p_p0, t_p0;
  logic [DATA_W-1:0]   g_p1, p_p1, t_p1;
  logic [DATA_W-1:0]   g_c, p_c, raw_diff, diff_c;
  logic                bo_c;
  logic [DATA_W-1:0]   diff_p2;
  logic                bo_p2;
  logic [2*DATA_W-1:0] gp_lo, gp_hi;

  assign load_p2   = !vld_p2 || OUT_READY;
  assign load_p1   = !vld_p1 || load_p2;
  assign IN_READY  = !RST && load_p1;
  assign in_fire   = IN_VALID && IN_READY;
  assign OUT_VALID = vld_p2;
  assign DIFF      = diff_p2;
  assign BO        = bo_p2;

  // Stage p0 -> p1: bitwise terms, carry-in folded into bit 0, prefix levels 1-2.
  always_comb begin
    gp_lo   = '0;
    t_p0    = A ^ ~B;
    g_p0    = A & ~B;
    p_p0    = A | ~B;
    g_p0[0] = g_p0[0] | p_p0[0];
    for (int l = 0; l < SPLIT; l++) begin
      gp_lo = prefix_level(g_p0, p_p0, l);
      g_p0  = gp_lo[2*DATA_W-1:DATA_W];
      p_p0  = gp_lo[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (in_fire) begin
      g_p1 <= g_p0;
      p_p1 <= p_p0;
      t_p1 <= t_p0;
    end
  end

  // Stage p1 -> p2: prefix levels 3-4, carries shifted up one bit with c[0] = 1.
  always_comb begin
    gp_hi = '0;
    g_c   = g_p1;
    p_c   = p_p1;
    for (int l = SPLIT; l < LEVELS; l++) begin
      gp_hi = prefix_level(g_c, p_c, l);
      g_c   = gp_hi[2*DATA_W-1:DATA_W];
      p_c   = gp_hi[DATA_W-1:0];
    end
  end

  assign raw_diff = t_p1 ^ {g_c[DATA_W-2:0], 1'b1};
  assign bo_c     = ~g_c[DATA_W-1];
`ifdef SKLANSKY_SUB_SAT_EN
  assign diff_c   = sat_floor(raw_diff, bo_c);
`else
  assign diff_c   = raw_diff;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      diff_p2 <= '0;
      bo_p2   <= 1'b0;
    end else begin
      if (load_p1) vld_p1 <= in_fire;
      if (load_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          diff_p2 <= diff_c;
          bo_p2   <= bo_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_sklansky_sub_pipe_16.sv
// Self-checking bench for sklansky_sub_pipe_16: directed corner vectors, stall/reset cases,
// and randomized traffic scored against an arithmetic A-B reference.
module tb_sklansky_sub_pipe_16;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BO;
  logic [15:0] A, B, DIFF;

  int errors = 0;
  int checks = 0;

  logic [16:0] exp_q[$];
  logic        held_vld;
  logic [15:0] held_diff;
  logic        held_bo;
  logic        last_accept;
  int          pops;

  sklansky_sub_pipe_16 dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DIFF(DIFF), .BO(BO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {borrow, difference} from plain unsigned subtraction.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b};
`ifdef SKLANSKY_SUB_SAT_EN
    if (a < b) r[15:0] = 16'h0000;
`endif
    return {(a < b), r[15:0]};
  endfunction

  // One clock: settle inputs, score handshakes seen before the edge, then advance past it.
  task automatic step();
    logic [16:0] e;
    #3;
    if (held_vld && !RST) begin
      check("hold_valid", {31'b0, OUT_VALID}, 32'd1);
      check("hold_diff", {16'b0, DIFF}, {16'b0, held_diff});
      check("hold_bo", {31'b0, BO}, {31'b0, held_bo});
    end
    if (OUT_VALID && OUT_READY && !RST) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, OUT_VALID}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        pops++;
        check("diff", {16'b0, DIFF}, {16'b0, e[15:0]});
        check("bo", {31'b0, BO}, {31'b0, e[16]});
      end
    end
    held_vld  = OUT_VALID && !OUT_READY && !RST;
    held_diff = DIFF;
    held_bo   = BO;
    last_accept = IN_VALID && IN_READY;
    if (last_accept) exp_q.push_back(model(A, B));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    step();
    exp_q.delete();
    held_vld = 1'b0;
    check("rst_in_ready", {31'b0, IN_READY}, 32'd0);
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_diff", {16'b0, DIFF}, 32'd0);
    check("rst_bo", {31'b0, BO}, 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, IN_READY}, 32'd1);
  endtask

  // Single isolated vector into an empty pipeline with constant expectations.
  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic eb, input string tag);
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = a; B = b;
    step();
    IN_VALID = 1'b0;
    step();
    check({tag, "_vld"}, {31'b0, OUT_VALID}, 32'd1);
    check({tag, "_diff"}, {16'b0, DIFF}, {16'b0, ed});
    check({tag, "_bo"}, {31'b0, BO}, {31'b0, eb});
    step();
  endtask

  initial begin
    logic [15:0] sat_ffff;
    int accepted, n;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0;
    held_vld = 1'b0; pops = 0; last_accept = 1'b0;
`ifdef SKLANSKY_SUB_SAT_EN
    sat_ffff = 16'h0000;
`else
    sat_ffff = 16'hFFFF;
`endif
    @(posedge CLK); #1;
    do_reset();

    run_vec(16'h0000, 16'h0001, sat_ffff, 1'b1, "zero_minus_one");
    run_vec(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, "equal");
    run_vec(16'h8000, 16'h0001, 16'h7FFF, 1'b0, "msb_borrow");

    // Back-to-back pairs, full throughput.
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = 16'h1234; B = 16'h0234;
    step();
    check("b2b_empty_e1", {31'b0, OUT_VALID}, 32'd0);
    A = 16'hAAAA; B = 16'h5555;
    step();
    check("b2b_r1_diff", {16'b0, DIFF}, 32'h1000);
    check("b2b_r1_bo", {31'b0, BO}, 32'd0);
    A = 16'h0001; B = 16'h0002;
    step();
    check("b2b_r2_diff", {16'b0, DIFF}, 32'h5555);
    check("b2b_r2_bo", {31'b0, BO}, 32'd0);
    IN_VALID = 1'b0;
    step();
    check("b2b_r3_diff", {16'b0, DIFF}, {16'b0, sat_ffff});
    check("b2b_r3_bo", {31'b0, BO}, 32'd1);
    step();
    step();

    // Full stall with three pairs offered.
    OUT_READY = 1'b0; accepted = 0; pops = 0;
    for (int c = 0; c < 4; c++) begin
      IN_VALID = 1'b1; A = 16'h1000 + 16'(accepted); B = 16'h0100;
      step();
      if (last_accept) accepted++;
    end
    check("stall_accepts", accepted, 32'd2);
    check("stall_in_ready", {31'b0, IN_READY}, 32'd0);
    check("stall_first_diff", {16'b0, DIFF}, 32'h0F00);
    OUT_READY = 1'b1;
    n = 0;
    while (accepted < 3 && n < 10) begin
      A = 16'h1000 + 16'(accepted); B = 16'h0100;
      step();
      if (last_accept) accepted++;
      n++;
    end
    IN_VALID = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin step(); n++; end
    check("stall_results", pops, 32'd3);

    // Reset with two pairs in flight.
    OUT_READY = 1'b0; IN_VALID = 1'b1; A = 16'h4444; B = 16'h1111;
    step(); step();
    IN_VALID = 1'b0;
    do_reset();
    OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_stale", {31'b0, OUT_VALID}, 32'd0);
    end

    // Randomized traffic with random backpressure; sender holds A/B until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!IN_VALID || last_accept) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: begin A = 16'h0000; B = 16'($urandom); end
          1: begin A = 16'($urandom); B = A; end
          2: begin A = 16'hFFFF; B = 16'($urandom); end
          default: begin A = 16'($urandom); B = 16'($urandom); end
        endcase
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(); n++; end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
